front_panel_debounce: RTL and testbench

Front-panel input conditioner for the microwave controller. Synchronizes and debounces the raw 10-key numeric pad, the start/stop/clear push-buttons and the door switch. Delivers clean levels to the time-entry/control, magnetron-control and minutes/seconds counter stages. The keypad output is either a stable one-hot code or all-zero, never a glitch or a multi-key chord.

---
 rtl/front_panel_debounce_if.sv | 26 ++
 rtl/front_panel_debounce.sv | 213 +++++++++++++++++++++
 tb/tb_front_panel_debounce.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/front_panel_debounce_if.sv
// Front-panel signal bundle: raw contacts from the panel, clean levels back.
// The panel side (or a test driver) uses master; the debouncer uses slave.
interface front_panel_debounce_if;
  logic [9:0] raw_keys;
  logic       raw_startn;
  logic       raw_stopn;
  logic       raw_clearn;
  logic       raw_door_closed;

  logic [9:0] keypad;
  logic       key_strobe;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;

  modport master (
    output raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    input  keypad, key_strobe, startn, stopn, clearn, door_closed
  );

  modport slave (
    input  raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    output keypad, key_strobe, startn, stopn, clearn, door_closed
  );
endinterface

// File: rtl/front_panel_debounce.sv
// Front-panel input conditioner: two-flop synchronizers, per-line debounce
// for start/stop/clear/door, and a keypad FSM that only ever reports a
// stable single key (one-hot) or nothing.

// One scalar channel: synchronizer plus a counter that lets the output
// follow the synced input only after DEBOUNCE_CYCLES consecutive
// differing cycles.
module fpd_chan #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic out
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             out_q,  out_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // synchronizer stage inputs and debounce counter next-state
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    if (sync_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // state registers; reset value doubles as the "safe" level of the line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      out_q  <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out = out_q;
endmodule

module front_panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  front_panel_debounce_if.slave  fp
);
  localparam int NUM_CH = 4;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The IDLE cycle that captures the snapshot already counts as one stable
  // cycle, so QUAL needs only DEBOUNCE_CYCLES-1 more matching cycles. This
  // keeps press latency equal to release latency (sync + DEBOUNCE_CYCLES).
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  // channel order: start, stop, clear (idle high), door (reset as open)
  localparam logic [NUM_CH-1:0] CH_RST = 4'b0111;

  // ---------------------------------------------------------------------
  // Button and door channels
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] ch_raw;
  logic [NUM_CH-1:0] ch_out;

  assign ch_raw = {fp.raw_door_closed, fp.raw_clearn, fp.raw_stopn, fp.raw_startn};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    fpd_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (CH_RST[i])
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .raw    (ch_raw[i]),
      .out    (ch_out[i])
    );
  end

  assign fp.startn      = ch_out[0];
  assign fp.stopn       = ch_out[1];
  assign fp.clearn      = ch_out[2];
  assign fp.door_closed = ch_out[3];

  // ---------------------------------------------------------------------
  // Keypad
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_QUAL    = 2'd1,
    KP_PRESSED = 2'd2,
    KP_LOCKOUT = 2'd3
  } kp_state_e;

  kp_state_e        state_q,  state_d;
  logic [9:0]       key_meta_q, key_meta_d;
  logic [9:0]       key_sync_q, key_sync_d;
  logic [9:0]       snap_q,   snap_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [9:0]       keypad_q, keypad_d;
  logic             strobe_q, strobe_d;
  logic [9:0]       s;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

  assign s = key_sync_q;

  // keypad synchronizer inputs
  always_comb begin
    key_meta_d = fp.raw_keys;
    key_sync_d = key_meta_q;
  end

  // keypad FSM next-state and registered outputs
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    keypad_d = keypad_q;
    strobe_d = 1'b0;
    unique case (state_q)
      KP_IDLE: begin
        keypad_d = '0;
        if (s != '0) begin
          snap_d  = s;
          cnt_d   = '0;
          state_d = KP_QUAL;
        end
      end
      KP_QUAL: begin
        if (s == '0) begin
          cnt_d   = '0;
          state_d = KP_IDLE;
        end else if (s != snap_q) begin
          snap_d = s;
          cnt_d  = '0;
        end else if (cnt_q == QUAL_LAST) begin
          cnt_d = '0;
          if (is_onehot(snap_q)) begin
            keypad_d = snap_q;
            strobe_d = 1'b1;
            state_d  = KP_PRESSED;
          end else begin
            state_d = KP_LOCKOUT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // PRESSED and LOCKOUT both wait for a debounced all-released pad;
      // any nonzero sample (extra keys, bounce) restarts the release count.
      KP_PRESSED, KP_LOCKOUT: begin
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          keypad_d = '0;
          state_d  = KP_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        keypad_d = '0;
        cnt_d    = '0;
        state_d  = KP_IDLE;
      end
    endcase
  end

  // keypad state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
      state_q    <= KP_IDLE;
      snap_q     <= '0;
      cnt_q      <= '0;
      keypad_q   <= '0;
      strobe_q   <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      state_q    <= state_d;
      snap_q     <= snap_d;
      cnt_q      <= cnt_d;
      keypad_q   <= keypad_d;
      strobe_q   <= strobe_d;
    end
  end

  assign fp.keypad     = keypad_q;
  assign fp.key_strobe = strobe_q;
endmodule

// File: tb/tb_front_panel_debounce.sv
// Directed bench for front_panel_debounce with DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, so "after N falls" means "after rising edge N".
module tb_front_panel_debounce;
  localparam int DC = 4;
  localparam int LAT = DC + 2;

  logic clk;
  logic resetn;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_strobe = 0;
  int   base;

  front_panel_debounce_if fp();

  front_panel_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fp     (fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (fp.key_strobe) n_strobe++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held with a key and all buttons pressed
    resetn             = 1'b0;
    fp.raw_keys        = 10'h004;
    fp.raw_startn      = 1'b0;
    fp.raw_stopn       = 1'b0;
    fp.raw_clearn      = 1'b0;
    fp.raw_door_closed = 1'b0;
    cyc(3);
    chk("rst_keypad", 32'(fp.keypad), 32'h0);
    chk("rst_strobe", 32'(fp.key_strobe), 32'h0);
    chk("rst_startn", 32'(fp.startn), 32'h1);
    chk("rst_stopn",  32'(fp.stopn),  32'h1);
    chk("rst_clearn", 32'(fp.clearn), 32'h1);
    chk("rst_door",   32'(fp.door_closed), 32'h0);

    // release: held key and buttons show up after full latency
    base = n_strobe;
    resetn = 1'b1;
    cyc(LAT - 1);
    chk("rel_keypad_early", 32'(fp.keypad), 32'h0);
    chk("rel_startn_early", 32'(fp.startn), 32'h1);
    cyc(1);
    chk("rel_keypad", 32'(fp.keypad), 32'h004);
    chk("rel_strobe", 32'(fp.key_strobe), 32'h1);
    chk("rel_startn", 32'(fp.startn), 32'h0);
    chk("rel_clearn", 32'(fp.clearn), 32'h0);
    cyc(1);
    chk("rel_strobe_off", 32'(fp.key_strobe), 32'h0);
    chk("rel_strobe_cnt", 32'(n_strobe - base), 32'd1);
    fp.raw_keys   = '0;
    fp.raw_startn = 1'b1;
    fp.raw_stopn  = 1'b1;
    fp.raw_clearn = 1'b1;
    cyc(10);
    chk("idle_keypad", 32'(fp.keypad), 32'h0);
    chk("idle_startn", 32'(fp.startn), 32'h1);

    // clean press and release
    base = n_strobe;
    fp.raw_keys = 10'h020;
    cyc(LAT - 1);
    chk("clean_early", 32'(fp.keypad), 32'h0);
    cyc(1);
    chk("clean_keypad", 32'(fp.keypad), 32'h020);
    chk("clean_strobe", 32'(fp.key_strobe), 32'h1);
    cyc(1);
    chk("clean_strobe_off", 32'(fp.key_strobe), 32'h0);
    cyc(20 - LAT - 1);
    chk("clean_hold", 32'(fp.keypad), 32'h020);
    chk("clean_one_strobe", 32'(n_strobe - base), 32'd1);
    fp.raw_keys = '0;
    cyc(LAT - 1);
    chk("clean_rel_early", 32'(fp.keypad), 32'h020);
    cyc(1);
    chk("clean_rel", 32'(fp.keypad), 32'h0);
    cyc(4);

    // bounce: 2-cycle toggling never qualifies
    base = n_strobe;
    for (int k = 0; k < 6; k++) begin
      fp.raw_keys = (k % 2 == 0) ? 10'h001 : 10'h000;
      cyc(2);
      chk("bounce_keypad", 32'(fp.keypad), 32'h0);
    end
    fp.raw_keys = 10'h001;
    cyc(LAT - 1);
    chk("bounce_early", 32'(fp.keypad), 32'h0);
    chk("bounce_no_strobe", 32'(n_strobe - base), 32'd0);
    cyc(1);
    chk("bounce_keypad_final", 32'(fp.keypad), 32'h001);
    fp.raw_keys = '0;
    cyc(10);

    // chord locks out until a debounced all-release
    base = n_strobe;
    fp.raw_keys = 10'h003;
    cyc(10);
    chk("chord_keypad", 32'(fp.keypad), 32'h0);
    fp.raw_keys = '0;
    cyc(3);
    fp.raw_keys = 10'h002;
    cyc(10);
    chk("chord_locked", 32'(fp.keypad), 32'h0);
    chk("chord_no_strobe", 32'(n_strobe - base), 32'd0);
    fp.raw_keys = '0;
    cyc(6);
    fp.raw_keys = 10'h002;
    cyc(LAT - 1);
    chk("chord_exit_early", 32'(fp.keypad), 32'h0);
    cyc(1);
    chk("chord_exit_keypad", 32'(fp.keypad), 32'h002);
    chk("chord_exit_strobe", 32'(fp.key_strobe), 32'h1);
    fp.raw_keys = '0;
    cyc(10);

    // start button: short pulse filtered, long press accepted
    fp.raw_startn = 1'b0;
    cyc(3);
    fp.raw_startn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("start_glitch", 32'(fp.startn), 32'h1);
    end
    fp.raw_startn = 1'b0;
    fp.raw_stopn  = 1'b0;
    cyc(LAT - 1);
    chk("start_early", 32'(fp.startn), 32'h1);
    cyc(1);
    chk("start_press", 32'(fp.startn), 32'h0);
    chk("stop_press",  32'(fp.stopn),  32'h0);
    cyc(2);
    fp.raw_startn = 1'b1;
    fp.raw_stopn  = 1'b1;
    cyc(LAT - 1);
    chk("start_rel_early", 32'(fp.startn), 32'h0);
    cyc(1);
    chk("start_rel", 32'(fp.startn), 32'h1);

    // door close, 2-cycle open glitch filtered, then a real open
    fp.raw_door_closed = 1'b1;
    cyc(LAT - 1);
    chk("door_early", 32'(fp.door_closed), 32'h0);
    cyc(1);
    chk("door_closed", 32'(fp.door_closed), 32'h1);
    fp.raw_door_closed = 1'b0;
    cyc(2);
    fp.raw_door_closed = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("door_glitch", 32'(fp.door_closed), 32'h1);
    end
    fp.raw_door_closed = 1'b0;
    cyc(LAT - 1);
    chk("door_open_early", 32'(fp.door_closed), 32'h1);
    cyc(1);
    chk("door_open", 32'(fp.door_closed), 32'h0);
    fp.raw_door_closed = 1'b1;
    cyc(10);

    // asynchronous reset in the middle of a press
    fp.raw_keys = 10'h100;
    cyc(8);
    chk("midrst_pressed", 32'(fp.keypad), 32'h100);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_keypad", 32'(fp.keypad), 32'h0);
    chk("midrst_door",   32'(fp.door_closed), 32'h0);
    cyc(2);
    resetn = 1'b1;
    cyc(LAT - 1);
    chk("midrst_rel_early", 32'(fp.keypad), 32'h0);
    cyc(1);
    chk("midrst_rel_keypad", 32'(fp.keypad), 32'h100);
    chk("midrst_rel_door", 32'(fp.door_closed), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
